fifo_control: RTL and testbench



---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ptr.sv | 22 ++
 rtl/fifo_control.sv | 96 +++++++++
 tb/tb_fifo_control.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and status encoding for the circular-queue FIFO controller.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_status_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM address pointer; advances by one on each accepted request.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adv,
  output logic [ADDR_WIDTH-1:0] ptr
);

  // Natural rollover gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= ptr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_control.sv
// Head/tail pointer and status controller for a FIFO built on an external dual-port RAM.
module fifo_control
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_drop,
  output logic                  rd_drop
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  fifo_status_e          st_q;
  fifo_status_e          st_d;
  logic [ADDR_WIDTH:0]   count_d;
  logic                  empty_d;
  logic                  full_d;
  logic                  wr_drop_d;
  logic                  rd_drop_d;
  logic                  rd_ok;
  logic                  wr_ok;

  // A write into a full FIFO is fine when a read frees a slot on the same edge.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);
  assign w_en  = wr_ok & ~reset;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_tail (
    .clk   (clk),
    .reset (reset),
    .adv   (wr_ok),
    .ptr   (w_addr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_head (
    .clk   (clk),
    .reset (reset),
    .adv   (rd_ok),
    .ptr   (r_addr)
  );

  always_comb begin
    st_d      = st_q;
    count_d   = count + CW'(wr_ok) - CW'(rd_ok);
    wr_drop_d = wr & ~wr_ok;
    rd_drop_d = rd & ~rd_ok;

    case (st_q)
      ST_EMPTY: begin
        if (wr_ok) st_d = (count_d == DEPTH) ? ST_FULL : ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (count_d == '0)        st_d = ST_EMPTY;
        else if (count_d == DEPTH) st_d = ST_FULL;
      end
      ST_FULL: begin
        if (rd_ok && !wr_ok) st_d = (count_d == '0) ? ST_EMPTY : ST_PARTIAL;
      end
      default: st_d = ST_EMPTY;
    endcase

    empty_d = (st_d == ST_EMPTY);
    full_d  = (st_d == ST_FULL);
  end

  // Status, occupancy and drop pulses all move on the same edge as the pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= ST_EMPTY;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      wr_drop <= 1'b0;
      rd_drop <= 1'b0;
    end else begin
      st_q    <= st_d;
      count   <= count_d;
      empty   <= empty_d;
      full    <= full_d;
      wr_drop <= wr_drop_d;
      rd_drop <= rd_drop_d;
    end
  end

endmodule

// File: tb/tb_fifo_control.sv
// Randomised and directed bench for fifo_control against a totals-based queue model.
module tb_fifo_control;
  import fifo_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       w_en;
  logic [2:0] w_addr;
  logic [2:0] r_addr;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       wr_drop;
  logic       rd_drop;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: total accepted writes/reads since reset; occupancy is their difference.
  int   m_wtot = 0;
  int   m_rtot = 0;
  logic m_wen = 1'b0;
  logic m_wdrop = 1'b0;
  logic m_rdrop = 1'b0;
  logic obs_wen = 1'b0;
  bit   chk_on = 1'b0;

  fifo_control #(.ADDR_WIDTH(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .rd      (rd),
    .w_en    (w_en),
    .w_addr  (w_addr),
    .r_addr  (r_addr),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .wr_drop (wr_drop),
    .rd_drop (rd_drop)
  );

  always #5 clk = ~clk;

  // Every cycle: outputs against the model, plus the pointer/count invariant.
  always @(negedge clk) begin
    int mc;
    fifo_status_e m_st;
    fifo_status_e d_st;
    if (chk_on) begin
      mc   = m_wtot - m_rtot;
      m_st = (mc == 0) ? ST_EMPTY : (mc == DEPTH) ? ST_FULL : ST_PARTIAL;
      d_st = empty ? ST_EMPTY : full ? ST_FULL : ST_PARTIAL;
      n_cmp += 8;
      if (w_en !== m_wen) begin n_fail++; $display("FAIL cyc_w_en got=%0b exp=%0b t=%0t", w_en, m_wen, $time); end
      if (w_addr !== 3'(m_wtot)) begin n_fail++; $display("FAIL cyc_w_addr got=%0d exp=%0d t=%0t", w_addr, 3'(m_wtot), $time); end
      if (r_addr !== 3'(m_rtot)) begin n_fail++; $display("FAIL cyc_r_addr got=%0d exp=%0d t=%0t", r_addr, 3'(m_rtot), $time); end
      if (count !== 4'(mc)) begin n_fail++; $display("FAIL cyc_count got=%0d exp=%0d t=%0t", count, mc, $time); end
      if ({empty, full} !== {mc == 0, mc == DEPTH} || d_st !== m_st) begin
        n_fail++; $display("FAIL cyc_flags got empty=%0b full=%0b exp count=%0d t=%0t", empty, full, mc, $time);
      end
      if (wr_drop !== m_wdrop) begin n_fail++; $display("FAIL cyc_wr_drop got=%0b exp=%0b t=%0t", wr_drop, m_wdrop, $time); end
      if (rd_drop !== m_rdrop) begin n_fail++; $display("FAIL cyc_rd_drop got=%0b exp=%0b t=%0t", rd_drop, m_rdrop, $time); end
      if (3'(w_addr - r_addr) !== count[2:0]) begin
        n_fail++; $display("FAIL cyc_invariant w_addr=%0d r_addr=%0d count=%0d t=%0t", w_addr, r_addr, count, $time);
      end
    end
  end

  task automatic reset_model();
    m_wtot = 0; m_rtot = 0; m_wen = 1'b0; m_wdrop = 1'b0; m_rdrop = 1'b0;
  endtask

  // One request cycle; entered and left at posedge+1.
  task automatic drive(input logic w, input logic r);
    int   mc;
    logic rok;
    logic wok;
    mc  = m_wtot - m_rtot;
    rok = r && (mc > 0);
    wok = w && ((mc < DEPTH) || rok);
    wr = w; rd = r; m_wen = wok;
    #1 obs_wen = w_en;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; m_wen = 1'b0;
    if (wok) m_wtot++;
    if (rok) m_rtot++;
    m_wdrop = w && !wok;
    m_rdrop = r && !rok;
  endtask

  task automatic apply_reset();
    chk_on = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    reset_model();
    chk_on = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    chk_on = 1'b0;
    reset = 1'b1;
    wr = 1'b1;
    #1;
    n_cmp++;
    if (w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en got=%0b exp=0", w_en); end
    wr = 1'b0;
    apply_reset();
    repeat (4) drive(1'b0, 1'b0);
    n_cmp++;
    if ({w_addr, r_addr, count, empty, full, wr_drop, rd_drop, obs_wen} !== {3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_idle got w=%0d r=%0d cnt=%0d e=%0b f=%0b wd=%0b rd=%0b wen=%0b exp 0 0 0 1 0 0 0 0",
               w_addr, r_addr, count, empty, full, wr_drop, rd_drop, obs_wen);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (w_addr !== 3'(i)) begin n_fail++; $display("FAIL fill_w_addr got=%0d exp=%0d", w_addr, i); end
      drive(1'b1, 1'b0);
      n_cmp++;
      if (obs_wen !== 1'b1) begin n_fail++; $display("FAIL fill_w_en got=%0b exp=1", obs_wen); end
    end
    n_cmp++;
    if ({count, full, empty, w_addr} !== {4'd8, 1'b1, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL fill_full got cnt=%0d f=%0b e=%0b w=%0d exp 8 1 0 0", count, full, empty, w_addr);
    end
    drive(1'b1, 1'b0);
    n_cmp++;
    if ({obs_wen, wr_drop, count, w_addr} !== {1'b0, 1'b1, 4'd8, 3'd0}) begin
      n_fail++; $display("FAIL fill_overflow got wen=%0b wd=%0b cnt=%0d w=%0d exp 0 1 8 0", obs_wen, wr_drop, count, w_addr);
    end
    drive(1'b0, 1'b0);
    n_cmp++;
    if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL fill_drop_pulse got=%0b exp=0", wr_drop); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (r_addr !== 3'(i) || count !== 4'(DEPTH - i)) begin
        n_fail++; $display("FAIL drain_step got r=%0d cnt=%0d exp %0d %0d", r_addr, count, i, DEPTH - i);
      end
      drive(1'b0, 1'b1);
    end
    n_cmp++;
    if ({count, empty, full, r_addr} !== {4'd0, 1'b1, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL drain_empty got cnt=%0d e=%0b f=%0b r=%0d exp 0 1 0 0", count, empty, full, r_addr);
    end
    drive(1'b0, 1'b1);
    n_cmp++;
    if ({rd_drop, r_addr, count} !== {1'b1, 3'd0, 4'd0}) begin
      n_fail++; $display("FAIL drain_underflow got rd=%0b r=%0d cnt=%0d exp 1 0 0", rd_drop, r_addr, count);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 1'b1);
    n_cmp++;
    if ({obs_wen, count, rd_drop, wr_drop, r_addr, w_addr} !== {1'b1, 4'd1, 1'b1, 1'b0, 3'd0, 3'd1}) begin
      n_fail++; $display("FAIL simul_empty got wen=%0b cnt=%0d rd=%0b wd=%0b r=%0d w=%0d exp 1 1 1 0 0 1",
                         obs_wen, count, rd_drop, wr_drop, r_addr, w_addr);
    end
    repeat (DEPTH - 1) drive(1'b1, 1'b0);
    n_cmp++;
    if ({full, count, w_addr} !== {1'b1, 4'd8, 3'd0}) begin
      n_fail++; $display("FAIL simul_refill got f=%0b cnt=%0d w=%0d exp 1 8 0", full, count, w_addr);
    end
    drive(1'b1, 1'b1);
    n_cmp++;
    if ({obs_wen, w_addr, r_addr, count, full, wr_drop, rd_drop} !== {1'b1, 3'd1, 3'd1, 4'd8, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL simul_full got wen=%0b w=%0d r=%0d cnt=%0d f=%0b wd=%0b rd=%0b exp 1 1 1 8 1 0 0",
                         obs_wen, w_addr, r_addr, count, full, wr_drop, rd_drop);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    repeat (5) drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b1);
    repeat (6) drive(1'b1, 1'b0);
    n_cmp++;
    if ({count, full} !== {4'd8, 1'b1}) begin n_fail++; $display("FAIL wrap_mid got cnt=%0d f=%0b exp 8 1", count, full); end
    repeat (8) drive(1'b0, 1'b1);
    n_cmp++;
    if ({count, empty, w_addr, r_addr} !== {4'd0, 1'b1, 3'd3, 3'd3}) begin
      n_fail++; $display("FAIL wrap_end got cnt=%0d e=%0b w=%0d r=%0d exp 0 1 3 3", count, empty, w_addr, r_addr);
    end
  endtask

  task automatic test_random();
    logic w;
    logic r;
    for (int i = 0; i < 600; i++) begin
      // Alternate write-heavy and read-heavy phases so both boundaries are hit often.
      if ((i / 40) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
      end
      drive(w, r);
    end
    n_cmp++;
    if (count !== 4'(m_wtot - m_rtot)) begin
      n_fail++; $display("FAIL random_count got=%0d exp=%0d", count, m_wtot - m_rtot);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    #2;
    chk_on = 1'b0;
    wr = 1'b1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({w_addr, r_addr, count, empty, full, wr_drop, rd_drop, w_en} !== {3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset got w=%0d r=%0d cnt=%0d e=%0b f=%0b wd=%0b rd=%0b wen=%0b exp 0 0 0 1 0 0 0 0",
               w_addr, r_addr, count, empty, full, wr_drop, rd_drop, w_en);
    end
    wr = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    reset_model();
    chk_on = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0);
    n_cmp++;
    if ({count, w_addr, empty} !== {4'd1, 3'd1, 1'b0}) begin
      n_fail++; $display("FAIL async_recover got cnt=%0d w=%0d e=%0b exp 1 1 0", count, w_addr, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_random();
    test_async_reset();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
